// File: rtl/if_id_stage_reg.sv
// IF/ID decoupling register: small circular skid buffer between fetch and decode.
// Optional perf counters are compiled in with IF_ID_PERF_CNT_EN.
module if_id_stage_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_bubble,
    output logic [31:0]        perf_flush
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_d;
    logic               push;
    logic               pop;

    // Handshake flags depend on registered state only.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_q[rd_ptr] : '0;

    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count + CNT_ONE;
                2'b01:   count_d = count - CNT_ONE;
                default: count_d = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr]    <= in_pc;
            instr_q[wr_ptr] <= in_instr;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;
    logic [31:0] flush_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (out_valid && !out_ready && !flush) stall_q <= stall_q + 32'd1;
            if (!out_valid) bubble_q <= bubble_q + 32'd1;
            if (flush)      flush_q  <= flush_q + 32'd1;
        end
    end

    assign perf_stall  = stall_q;
    assign perf_bubble = bubble_q;
    assign perf_flush  = flush_q;
`else
    assign perf_stall  = 32'd0;
    assign perf_bubble = 32'd0;
    assign perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg with a queue model of the buffer contents.
module tb_if_id_stage_reg;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;
    logic [31:0] perf_flush;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    int unsigned m_stall = 0;
    int unsigned m_bubble = 0;
    int unsigned m_flush = 0;

    always #5 clk = ~clk;

    if_id_stage_reg #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble),
        .perf_flush(perf_flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [63:0] h;
        h = (sb.size() != 0) ? sb[0] : 64'd0;
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("out_pc", 64'(out_pc), 64'(h[63:32]));
        chk("out_instr", 64'(out_instr), 64'(h[31:0]));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_stall", 64'(perf_stall), 64'(m_stall));
        chk("perf_bubble", 64'(perf_bubble), 64'(m_bubble));
        chk("perf_flush", 64'(perf_flush), 64'(m_flush));
`else
        chk("perf_stall", 64'(perf_stall), 64'd0);
        chk("perf_bubble", 64'(perf_bubble), 64'd0);
        chk("perf_flush", 64'(perf_flush), 64'd0);
`endif
    endtask

    // Called at posedge+1: checks mid-cycle, updates the model, crosses one edge.
    task automatic tick();
        bit mpush;
        bit mpop;
        if (!rst) begin
            sb.delete();
            m_stall = 0;
            m_bubble = 0;
            m_flush = 0;
        end
        #3;
        check_outs();
        if (rst) begin
            if (sb.size() != 0 && !out_ready && !flush) m_stall++;
            if (sb.size() == 0) m_bubble++;
            if (flush) m_flush++;
            mpush = in_valid && (sb.size() < DEPTH) && !flush;
            mpop  = (sb.size() != 0) && out_ready && !flush;
            if (flush) begin
                sb.delete();
            end else begin
                if (mpop) void'(sb.pop_front());
                if (mpush) sb.push_back({in_pc, in_instr});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = 32'h1000_0000 | pc;
    endtask

    task automatic push_one(input logic [31:0] pc);
        drive(pc);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset held three cycles with in_valid high
        #1;
        rst = 1'b0;
        drive(32'h4);
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        in_pc = 32'h4;
        in_instr = 32'h2001_0005;
        tick();
        in_valid = 1'b0;
        chk("first_pc", 64'(out_pc), 64'h4);
        chk("first_instr", 64'(out_instr), 64'h2001_0005);
        out_ready = 1'b1;
        tick();
        tick();

        // Streaming with out_ready high
        for (int i = 1; i <= 4; i++) begin
            drive(32'(4 * i));
            tick();
            chk("stream_pc", 64'(out_pc), 64'(4 * i));
            chk("stream_rdy", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty", 64'(out_valid), 64'd0);

        // Stall until full, then drain
        out_ready = 1'b0;
        push_one(32'h4);
        push_one(32'h8);
        chk("full_rdy", 64'(in_ready), 64'd0);
        drive(32'hC);
        tick();
        tick();
        chk("held_head", 64'(out_pc), 64'h4);
        out_ready = 1'b1;
        tick();
        chk("pop1_rdy", 64'(in_ready), 64'd1);
        chk("pop1_pc", 64'(out_pc), 64'h8);
        tick();
        in_valid = 1'b0;
        chk("pop2_pc", 64'(out_pc), 64'hC);
        tick();
        tick();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Flush while full, with a fetch in the flush cycle
        out_ready = 1'b0;
        push_one(32'h4);
        push_one(32'h8);
        flush = 1'b1;
        drive(32'hC);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'd0);
        chk("flush_rdy", 64'(in_ready), 64'd1);
        push_one(32'h40);
        chk("post_flush_pc", 64'(out_pc), 64'h40);
        out_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset between edges with two entries buffered
        out_ready = 1'b0;
        push_one(32'h4);
        push_one(32'h8);
        chk("pre_arst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", 64'(out_pc), 64'd0);
        chk("arst_instr", 64'(out_instr), 64'd0);
        chk("arst_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        tick();

        // Perf trace: 3 bubbles, 3 stalls, 1 flush
        rst = 1'b1;
        tick();
        tick();
        push_one(32'h4);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
        chk("perf_stall_end", 64'(perf_stall), 64'd3);
        chk("perf_bubble_end", 64'(perf_bubble), 64'd3);
        chk("perf_flush_end", 64'(perf_flush), 64'd1);
`else
        chk("perf_stall_end", 64'(perf_stall), 64'd0);
        chk("perf_bubble_end", 64'(perf_bubble), 64'd0);
        chk("perf_flush_end", 64'(perf_flush), 64'd0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Decoupling pipeline register between the instruction-fetch stage and the instruction-decode stage.
- Accepts {pc, instruction} pairs from IF with a valid/ready handshake and holds them in a small circular buffer (skid buffer). Presents the oldest entry to ID.
- Absorbs one-cycle ID stalls without bubbles. Supports branch flush.
- IF drives its freeze input from !in_ready.

Parameters:
- PC_W, 32, width of the pc field (pc+4 of the fetched instruction, as produced by IF).
- INSTR_W, 32, instruction width.
- DEPTH, 2, buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  IF presents a valid fetch this cycle.
- in_pc  input  PC_W  pc+4 of the fetched instruction.
- in_instr  input  INSTR_W  fetched instruction.
- in_ready  output  1  buffer can accept; IF freeze = !in_ready.
- flush  input  1  branch taken in a later stage; discard all buffered entries.
- out_valid  output  1  head entry valid for ID.
- out_pc  output  PC_W  head pc.
- out_instr  output  INSTR_W  head instruction; 0 (NOP) when !out_valid.
- out_ready  input  1  ID consumes head this cycle (low = hazard stall).
- perf_stall  output  32  stall-cycle counter (see Optional Feature).
- perf_bubble  output  32  bubble-cycle counter.
- perf_flush  output  32  flush-event counter.

Behaviour:
- Storage: DEPTH x {pc, instr} registers. State is wr_ptr, rd_ptr (log2(DEPTH) bits, wrapping) and count (0..DEPTH).
- Reset (rst low, asynchronous): count=0, pointers=0, all entries cleared. Outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=1, perf counters=0.
- in_ready = (count != DEPTH). Combinational from registered state only; no path from out_ready or flush.
- push = in_valid && in_ready && !flush. Writes entry[wr_ptr], wr_ptr+1 (wraps at DEPTH).
- out_valid = (count != 0). out_pc/out_instr = entry[rd_ptr] when valid, else 0.
- pop = out_valid && out_ready && !flush. rd_ptr+1 (wraps).
- count_next = count + push - pop.
- Latency: push in cycle N means the entry is visible at the outputs in cycle N+1 (registered). There is no combinational in-to-out bypass.
- Full (count=DEPTH): in_ready=0, so IF holds. If pop occurs that cycle, in_ready rises next cycle.
- Empty plus push plus out_ready: no pop this cycle (out_valid=0). Entry is popped next cycle if out_ready stays high.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, head advances.
- Order is strict FIFO; entries never reorder or duplicate.
- flush: synchronous, highest priority. Next cycle count=0 and rd_ptr=wr_ptr=0. Any push or pop attempted in the flush cycle is discarded. in_valid data in the flush cycle is dropped; IF re-fetches the branch target next cycle.
- Flush while full: in_ready=1 next cycle.
- Reset asserted mid-operation: immediate clear as at reset; no partial state survives.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, cleared on reset, not cleared by flush.
  - perf_stall increments each cycle with out_valid && !out_ready && !flush.
  - perf_bubble increments each cycle with !out_valid.
  - perf_flush increments each cycle with flush=1.
- Undefined: counters are not instantiated; perf_* ports are tied to constant 0. Port list is unchanged.

Test Plan:
- Reset: hold rst low 3 cycles with in_valid=1 -> out_valid=0, out_instr=0, in_ready=1. After release, push pc=0x4/instr=0x20010005 -> that pair appears on outputs the next cycle.
- Streaming: out_ready=1, push pc 0x4,0x8,0xC,0x10 on consecutive cycles -> outputs show the same sequence each one cycle later, in_ready never drops, count never exceeds 1.
- Stall/full: out_ready=0, push 0x4,0x8 -> in_ready=0 after the second push. A third in_valid (0xC) is held by IF. Raise out_ready -> outputs 0x4,0x8,0xC in order; in_ready=1 one cycle after the first pop.
- Flush: buffer full (0x4,0x8), assert flush with in_valid=1 pc=0xC -> next cycle out_valid=0, out_instr=0, in_ready=1. 0xC is never output; the next push 0x40 is output first.
- Async reset mid-stream: drop rst between clock edges with count=2 -> outputs go to 0 immediately, without waiting for a clock edge.
- Perf counters (macro on): 3 stall cycles, 2 empty cycles, 1 flush -> perf_stall=3, perf_bubble>=2 (exact count from the bench's cycle trace), perf_flush=1. With the macro off, all perf_* outputs = 0.
